servo_bank: RTL and testbench



---
 rtl/servo_pkg.sv | 18 +
 rtl/servo_bank_if.sv | 14 +
 rtl/servo_channel.sv | 62 ++++++
 rtl/servo_bank.sv | 87 ++++++++
 tb/tb_servo_bank.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, pulse-width type and write-time clamp for servo_bank.
package servo_pkg;

    localparam int PERIOD_DEFAULT    = 240000;
    localparam int MIN_PULSE_DEFAULT = 12000;
    localparam int MAX_PULSE_DEFAULT = 24000;
    localparam int RAMP_STEP_DEFAULT = 240;

    typedef logic [15:0] pulse_t;
    typedef logic [3:0]  chan_t;

    function automatic pulse_t clamp_width(input pulse_t width, input pulse_t lo, input pulse_t hi);
        if (width < lo) return lo;
        if (width > hi) return hi;
        return width;
    endfunction

endpackage

// File: rtl/servo_bank_if.sv
// servo_bank_if: CPU peripheral bus port of servo_bank (width writes and active-width readback).
interface servo_bank_if;
    import servo_pkg::*;

    logic   wr_en;
    chan_t  wr_channel;
    pulse_t wr_data;
    chan_t  rd_channel;
    pulse_t rd_data;

    modport master (output wr_en, wr_channel, wr_data, rd_channel, input rd_data);
    modport slave  (input wr_en, wr_channel, wr_data, rd_channel, output rd_data);

endinterface

// File: rtl/servo_channel.sv
// servo_channel: one servo output with shadow/active width and pulse flop.
// Define SERVO_RAMP_EN to slew the active width toward the shadow by RAMP_STEP per frame.
module servo_channel
    import servo_pkg::*;
#(
    parameter int COUNT_W   = 18,
    parameter int MIN_PULSE = MIN_PULSE_DEFAULT
`ifdef SERVO_RAMP_EN
  , parameter int RAMP_STEP = RAMP_STEP_DEFAULT
`endif
) (
    input  logic               raw_clk,
    input  logic               reset,
    input  logic               frame_latch,
    input  logic [COUNT_W-1:0] count,
    input  logic               enable,
    input  logic               wr_strobe,
    input  pulse_t             wr_width,
    output pulse_t             active,
    output logic               servo
);

    pulse_t shadow;
    pulse_t next_active;
    logic   pulse_end;

`ifdef SERVO_RAMP_EN
    localparam pulse_t STEP_W = pulse_t'(RAMP_STEP);

    always_comb begin
        next_active = shadow;
        if (shadow > active && (shadow - active) > STEP_W)
            next_active = active + STEP_W;
        else if (active > shadow && (active - shadow) > STEP_W)
            next_active = active - STEP_W;
    end
`else
    assign next_active = shadow;
`endif

    // Only evaluated away from the latch cycle, so count is never 0 here.
    assign pulse_end = (32'(count) == 32'(active));

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            // NOTE: shadow/active are individual flops, not a RAM, so they take reset like any control state.
            shadow <= pulse_t'(MIN_PULSE);
            active <= pulse_t'(MIN_PULSE);
            servo  <= 1'b0;
        end else begin
            if (wr_strobe)
                shadow <= wr_width;
            if (frame_latch) begin
                active <= next_active;
                servo  <= enable;
            end else if (pulse_end) begin
                servo  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/servo_bank.sv
// servo_bank: N-channel servo pulse generator with frame counter, write decode and readback.
// Define SERVO_RAMP_EN to enable per-frame ramping of active widths.
module servo_bank
    import servo_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PERIOD    = PERIOD_DEFAULT,
    parameter int MIN_PULSE = MIN_PULSE_DEFAULT,
    parameter int MAX_PULSE = MAX_PULSE_DEFAULT,
    parameter int RAMP_STEP = RAMP_STEP_DEFAULT
) (
    input  logic                raw_clk,
    input  logic                reset,
    servo_bank_if.slave         bus,
    input  logic [CHANNELS-1:0] ch_enable,
    output logic [CHANNELS-1:0] servos,
    output logic                frame_start
);

    localparam int COUNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    if (CHANNELS < 1 || CHANNELS > 16 || MIN_PULSE > MAX_PULSE || MAX_PULSE >= PERIOD ||
        MAX_PULSE > 65535 || RAMP_STEP < 0) begin : g_bad_params
        $error("servo_bank: illegal parameter set");
    end

    logic [COUNT_W-1:0] count;
    logic               frame_latch;
    pulse_t             wr_width;
    pulse_t             active [CHANNELS];
    pulse_t             rd_next;

    assign frame_latch = (count == '0);

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            count       <= '0;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every flop in this edge sees the pre-edge count.
            frame_start <= frame_latch;
            count       <= (count == COUNT_W'(PERIOD - 1)) ? '0 : count + 1'b1;
        end
    end

    assign wr_width = clamp_width(bus.wr_data, pulse_t'(MIN_PULSE), pulse_t'(MAX_PULSE));

    // Out-of-range write channels match no instance and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_strobe;
        assign wr_strobe = bus.wr_en && (bus.wr_channel == chan_t'(i));

        servo_channel #(
            .COUNT_W   (COUNT_W),
            .MIN_PULSE (MIN_PULSE)
`ifdef SERVO_RAMP_EN
          , .RAMP_STEP (RAMP_STEP)
`endif
        ) u_channel (
            .raw_clk     (raw_clk),
            .reset       (reset),
            .frame_latch (frame_latch),
            .count       (count),
            .enable      (ch_enable[i]),
            .wr_strobe   (wr_strobe),
            .wr_width    (wr_width),
            .active      (active[i]),
            .servo       (servos[i])
        );
    end

    always_comb begin
        // NOTE: default first so no path leaves rd_next unassigned (no latch).
        rd_next = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (bus.rd_channel == chan_t'(i))
                rd_next = active[i];
    end

    always_ff @(posedge raw_clk) begin
        if (reset)
            bus.rd_data <= '0;
        else
            bus.rd_data <= rd_next;
    end

endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: directed plan plus randomized traffic against a frame-level reference model.
`timescale 1ns/1ps
module tb_servo_bank;
    import servo_pkg::*;

    localparam int CH     = 4;
    localparam int PERIOD = 200;
    localparam int MIN_P  = 40;
    localparam int MAX_P  = 80;
    localparam int STEP   = 10;

    logic          raw_clk = 1'b0;
    logic          reset   = 1'b1;
    logic [CH-1:0] ch_enable = '0;
    logic [CH-1:0] servos;
    logic          frame_start;

    servo_bank_if bus();

    servo_bank #(
        .CHANNELS  (CH),
        .PERIOD    (PERIOD),
        .MIN_PULSE (MIN_P),
        .MAX_PULSE (MAX_P),
        .RAMP_STEP (STEP)
    ) dut (
        .raw_clk     (raw_clk),
        .reset       (reset),
        .bus         (bus),
        .ch_enable   (ch_enable),
        .servos      (servos),
        .frame_start (frame_start)
    );

    always #5 raw_clk = ~raw_clk;

    // Reference model: widths per channel, enables latched per frame, position in frame.
    int shadow_m [CH];
    int active_m [CH];
    bit en_m     [CH];
    int count_m;
    int rd_exp;
    bit fs_exp;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int clamp_m(input int w);
        return (w < MIN_P) ? MIN_P : (w > MAX_P) ? MAX_P : w;
    endfunction

    function automatic int frame_width(input int act, input int shd);
`ifdef SERVO_RAMP_EN
        if (shd - act > STEP) return act + STEP;
        if (act - shd > STEP) return act - STEP;
`endif
        return shd;
    endfunction

    task automatic model_edge();
        if (reset) begin
            count_m = 0;
            rd_exp  = 0;
            fs_exp  = 0;
            for (int i = 0; i < CH; i++) begin
                shadow_m[i] = MIN_P;
                active_m[i] = MIN_P;
                en_m[i]     = 1'b0;
            end
            return;
        end
        rd_exp = (bus.rd_channel < CH) ? active_m[bus.rd_channel] : 0;
        fs_exp = (count_m == 0);
        if (count_m == 0)
            for (int i = 0; i < CH; i++) begin
                active_m[i] = frame_width(active_m[i], shadow_m[i]);
                en_m[i]     = ch_enable[i];
            end
        if (bus.wr_en && bus.wr_channel < CH)
            shadow_m[bus.wr_channel] = clamp_m(int'(bus.wr_data));
        count_m = (count_m + 1) % PERIOD;
    endtask

    // One clock: update the model at the edge, compare outputs on the falling edge.
    task automatic step();
        logic [CH-1:0] exp_servos;
        @(posedge raw_clk);
        model_edge();
        @(negedge raw_clk);
        for (int i = 0; i < CH; i++)
            exp_servos[i] = en_m[i] && count_m >= 1 && count_m <= active_m[i];
        check("servos", 32'(servos), 32'(exp_servos));
        check("frame_start", 32'(frame_start), 32'(fs_exp));
        check("rd_data", 32'(bus.rd_data), 32'(rd_exp));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input int ch, input int data);
        bus.wr_en      = 1'b1;
        bus.wr_channel = chan_t'(ch);
        bus.wr_data    = pulse_t'(data);
        step();
        bus.wr_en      = 1'b0;
    endtask

    // Leaves the bench just before a frame-latch edge.
    task automatic align_to_latch();
        int guard = 0;
        while (count_m != 0 && guard <= PERIOD) begin
            step();
            guard++;
        end
        if (count_m != 0) check("align_timeout", 32'(count_m), 32'd0);
    endtask

    task automatic read_active(input int ch, input int exp, input string tag);
        bus.rd_channel = chan_t'(ch);
        step();
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation ran out of time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_channel = '0;
        bus.wr_data    = '0;
        bus.rd_channel = '0;
        reset          = 1'b1;
        run(2);
        check("reset_servos", 32'(servos), 32'd0);

        // Writes land during frame one, so ch0 widens only from frame two.
        ch_enable = '1;
        reset     = 1'b0;
        write(0, 60);
        write(1, 40);
        run(2 * PERIOD);
        read_active(0, 60, "ch0_width");

        // Clamping in both directions.
        write(2, 100);
        align_to_latch();
        step();
        read_active(2, MAX_P, "clamp_hi");
        write(2, 10);
        align_to_latch();
        step();
        read_active(2, MIN_P, "clamp_lo");

        // A write on the latch edge waits a whole frame.
        align_to_latch();
        write(3, 50);
        read_active(3, MIN_P, "ch3_deferred");
        align_to_latch();
        step();
        read_active(3, 50, "ch3_applied");

        // Writes to a nonexistent channel change nothing.
        write(7, 70);
        run(PERIOD);

        // Dropping an enable mid-pulse finishes the pulse, then stays low.
        align_to_latch();
        run(10);
        ch_enable[1] = 1'b0;
        run(PERIOD + 10);
        ch_enable[1] = 1'b1;
        run(2 * PERIOD);

        // Reset in the middle of the pulses.
        align_to_latch();
        run(20);
        check("pre_reset_high", 32'(servos), 32'hF);
        reset = 1'b1;
        step();
        check("reset_mid_frame", 32'(servos), 32'd0);
        reset = 1'b0;
        run(PERIOD + 5);
        read_active(0, MIN_P, "post_reset_min");

        // Randomized traffic.
        for (int f = 0; f < 15; f++) begin
            repeat (PERIOD) begin
                bus.wr_en      = ($urandom_range(0, 15) == 0);
                bus.wr_channel = chan_t'($urandom_range(0, 7));
                bus.wr_data    = ($urandom_range(0, 9) == 0) ? pulse_t'($urandom_range(0, 65535))
                                                             : pulse_t'($urandom_range(0, 120));
                bus.rd_channel = chan_t'($urandom_range(0, 5));
                if ($urandom_range(0, 99) == 0)
                    ch_enable[$urandom_range(0, CH - 1)] ^= 1'b1;
                reset = ($urandom_range(0, 1499) == 0);
                step();
            end
        end
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        run(PERIOD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
